ni_rx_reassembly_sink: RTL and testbench

// - Receiving end of the NI flit link driven by source_from_memory: accepts flits {HDR,PL,ADDR} on req/busy.
// - Checks the destination address, buffers good payloads in a FWFT FIFO and presents them to a local consumer.
// - Raises busy for back-pressure. Keeps received and misroute statistics for the traffic benches.

---
 rtl/ni_rx_reassembly_sink.sv | 131 +++++++++++++
 tb/tb_ni_rx_reassembly_sink.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ni_rx_reassembly_sink.sv
// NI flit-link receiver: address check, FWFT payload FIFO, registered back-pressure and statistics.
// Optional random stalling via an LFSR is enabled by defining NI_RX_RANDOM_STALL_EN.
`ifndef HDR_SZ
`define HDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module ni_rx_reassembly_sink #(
    parameter int ID          = 0,
    parameter int DEPTH       = 4,
    parameter int HOSPITALITY = 255
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [`HDR_SZ+`PL_SZ+`ADDR_SZ-1:0]  data,
    input  logic                                req,
    output logic                                busy,
    output logic [`PL_SZ-1:0]                   pl_out,
    output logic [`HDR_SZ-1:0]                  src_out,
    output logic                                pl_valid,
    input  logic                                pl_ready,
    output logic [15:0]                         rx_count,
    output logic                                misroute,
    output logic [7:0]                          drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = `HDR_SZ + `PL_SZ + `ADDR_SZ;
    localparam int EW = `HDR_SZ + `PL_SZ;
    localparam logic [AW:0]         FULL       = DEPTH[AW:0];
    localparam logic [`ADDR_SZ-1:0] ID_ADDR    = ID[`ADDR_SZ-1:0];
    localparam bit                  CHECK_ADDR = (ID != -1);

    logic [EW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_next_s;
    logic          busy_r;
    logic          busy_next_s;
    logic [15:0]   rx_count_r;
    logic          misroute_r;
    logic [7:0]    drop_count_r;
    logic          accept_s;
    logic          addr_ok_s;
    logic          push_s;
    logic          drop_s;
    logic          pop_s;

    assign accept_s  = req && !busy_r;
    assign addr_ok_s = !CHECK_ADDR || (data[`ADDR_SZ-1:0] == ID_ADDR);
    assign push_s    = accept_s && addr_ok_s;
    assign drop_s    = accept_s && !addr_ok_s;
    assign pop_s     = (count_r != '0) && pl_ready;

    // Post-edge occupancy, used both for the count register and the busy decision
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 1'b1;
            2'b01:   count_next_s = count_r - 1'b1;
            default: count_next_s = count_r;
        endcase
    end

`ifdef NI_RX_RANDOM_STALL_EN
    localparam logic [7:0] HOSP8 = HOSPITALITY[7:0];
    localparam logic [7:0] SEED  = (ID == -1) ? 8'hA5 : (8'hA5 ^ ID[7:0]);
    logic [7:0] lfsr_r;
    logic [7:0] lfsr_next_s;

    assign lfsr_next_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    assign busy_next_s = (count_next_s == FULL) || (lfsr_next_s > HOSP8);

    // Free-running stall generator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= lfsr_next_s;
        end
    end
`else
    assign busy_next_s = (count_next_s == FULL);
`endif

    // FIFO storage, pointers, occupancy, back-pressure and statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            busy_r       <= 1'b0;
            rx_count_r   <= 16'd0;
            misroute_r   <= 1'b0;
            drop_count_r <= 8'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= data[FW-1:`ADDR_SZ];
                wr_ptr_r        <= wr_ptr_r + 1'b1;
                rx_count_r      <= rx_count_r + 16'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            if (drop_s) begin
                misroute_r <= 1'b1;
                if (drop_count_r != 8'hFF) begin
                    drop_count_r <= drop_count_r + 8'd1;
                end
            end
            count_r <= count_next_s;
            busy_r  <= busy_next_s;
        end
    end

    assign busy       = busy_r;
    assign pl_valid   = (count_r != '0);
    assign pl_out     = mem_r[rd_ptr_r][`PL_SZ-1:0];
    assign src_out    = mem_r[rd_ptr_r][EW-1:`PL_SZ];
    assign rx_count   = rx_count_r;
    assign misroute   = misroute_r;
    assign drop_count = drop_count_r;
endmodule

// File: tb/tb_ni_rx_reassembly_sink.sv
// Table-driven bench for ni_rx_reassembly_sink (ID=3, DEPTH=4) plus an ID=-1 instance checking the disabled address filter.
module tb_ni_rx_reassembly_sink;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data;
    logic        req;
    logic        pl_ready;
    logic        busy;
    logic [7:0]  pl_out;
    logic [3:0]  src_out;
    logic        pl_valid;
    logic [15:0] rx_count;
    logic        misroute;
    logic [7:0]  drop_count;

    logic        busy2;
    logic [7:0]  pl_out2;
    logic [3:0]  src_out2;
    logic        pl_valid2;
    logic [15:0] rx_count2;
    logic        misroute2;
    logic [7:0]  drop_count2;
    logic [15:0] req_cycles;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ni_rx_reassembly_sink #(.ID(3), .DEPTH(4), .HOSPITALITY(255)) dut (
        .clk(clk), .reset(reset), .data(data), .req(req), .busy(busy),
        .pl_out(pl_out), .src_out(src_out), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .rx_count(rx_count), .misroute(misroute), .drop_count(drop_count)
    );

    ni_rx_reassembly_sink #(.ID(-1), .DEPTH(4), .HOSPITALITY(255)) dut_any (
        .clk(clk), .reset(reset), .data(data), .req(req), .busy(busy2),
        .pl_out(pl_out2), .src_out(src_out2), .pl_valid(pl_valid2), .pl_ready(1'b1),
        .rx_count(rx_count2), .misroute(misroute2), .drop_count(drop_count2)
    );

    // The unfiltered, always-draining instance must accept every req cycle
    always @(posedge clk or posedge reset) begin
        if (reset) req_cycles <= 16'd0;
        else if (req) req_cycles <= req_cycles + 16'd1;
    end

    typedef struct {
        logic       req;
        logic [3:0] hdr;
        logic [7:0] pl;
        logic [3:0] addr;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_pl;
        logic [3:0] e_src;
        logic       e_busy;
        logic [15:0] e_rx;
        logic       e_mis;
        logic [7:0] e_drop;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic r, logic [3:0] h, logic [7:0] p, logic [3:0] a, logic rd,
                                logic ev, logic [7:0] ep, logic [3:0] es, logic eb,
                                logic [15:0] erx, logic em, logic [7:0] ed);
        vec_t v;
        v.req = r; v.hdr = h; v.pl = p; v.addr = a; v.rdy = rd;
        v.e_valid = ev; v.e_pl = ep; v.e_src = es; v.e_busy = eb;
        v.e_rx = erx; v.e_mis = em; v.e_drop = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] h, input logic [7:0] p,
                         input logic [3:0] a, input logic rd);
        req = r; data = {h, p, a}; pl_ready = rd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int pop_idx;

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'd0, 8'd0, 4'd0, 1'b0);
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, pl_valid}, 32'd0);
        chk("reset_rx", {16'd0, rx_count}, 32'd0);
        chk("reset_mis", {31'd0, misroute}, 32'd0);
        chk("reset_drop", {24'd0, drop_count}, 32'd0);
        chk("reset_pl", {24'd0, pl_out}, 32'd0);
        chk("reset_src", {28'd0, src_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        //           req hdr   pl     addr  rdy  valid e_pl   e_src busy rx      mis   drop
        tbl[0]  = mk(1, 4'd0, 8'h41, 4'd3, 0,   1, 8'h41, 4'd0, 0, 16'd1, 0, 8'd0);
        tbl[1]  = mk(0, 4'd0, 8'h00, 4'd0, 1,   0, 8'h00, 4'd0, 0, 16'd1, 0, 8'd0);
        tbl[2]  = mk(1, 4'd1, 8'hA0, 4'd3, 0,   1, 8'hA0, 4'd1, 0, 16'd2, 0, 8'd0);
        tbl[3]  = mk(1, 4'd2, 8'hA1, 4'd3, 0,   1, 8'hA0, 4'd1, 0, 16'd3, 0, 8'd0);
        tbl[4]  = mk(1, 4'd3, 8'hA2, 4'd3, 0,   1, 8'hA0, 4'd1, 0, 16'd4, 0, 8'd0);
        tbl[5]  = mk(1, 4'd4, 8'hA3, 4'd3, 0,   1, 8'hA0, 4'd1, 1, 16'd5, 0, 8'd0);
        tbl[6]  = mk(1, 4'd5, 8'hA4, 4'd3, 0,   1, 8'hA0, 4'd1, 1, 16'd5, 0, 8'd0);
        tbl[7]  = mk(1, 4'd5, 8'hA4, 4'd3, 1,   1, 8'hA1, 4'd2, 0, 16'd5, 0, 8'd0);
        tbl[8]  = mk(1, 4'd5, 8'hA4, 4'd3, 0,   1, 8'hA1, 4'd2, 1, 16'd6, 0, 8'd0);
        tbl[9]  = mk(0, 4'd0, 8'h00, 4'd0, 1,   1, 8'hA2, 4'd3, 0, 16'd6, 0, 8'd0);
        tbl[10] = mk(0, 4'd0, 8'h00, 4'd0, 1,   1, 8'hA3, 4'd4, 0, 16'd6, 0, 8'd0);
        tbl[11] = mk(0, 4'd0, 8'h00, 4'd0, 1,   1, 8'hA4, 4'd5, 0, 16'd6, 0, 8'd0);
        tbl[12] = mk(0, 4'd0, 8'h00, 4'd0, 1,   0, 8'h00, 4'd0, 0, 16'd6, 0, 8'd0);
        tbl[13] = mk(1, 4'd2, 8'h42, 4'd5, 1,   0, 8'h00, 4'd0, 0, 16'd6, 1, 8'd1);
        tbl[14] = mk(1, 4'd7, 8'h55, 4'd3, 0,   1, 8'h55, 4'd7, 0, 16'd7, 1, 8'd1);
        tbl[15] = mk(0, 4'd0, 8'h00, 4'd0, 1,   0, 8'h00, 4'd0, 0, 16'd7, 1, 8'd1);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].req, tbl[i].hdr, tbl[i].pl, tbl[i].addr, tbl[i].rdy);
            tick();
            chk($sformatf("v%0d_valid", i), {31'd0, pl_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
            chk($sformatf("v%0d_rx", i), {16'd0, rx_count}, {16'd0, tbl[i].e_rx});
            chk($sformatf("v%0d_mis", i), {31'd0, misroute}, {31'd0, tbl[i].e_mis});
            chk($sformatf("v%0d_drop", i), {24'd0, drop_count}, {24'd0, tbl[i].e_drop});
            if (tbl[i].e_valid) begin
                chk($sformatf("v%0d_pl", i), {24'd0, pl_out}, {24'd0, tbl[i].e_pl});
                chk($sformatf("v%0d_src", i), {28'd0, src_out}, {28'd0, tbl[i].e_src});
            end
        end

        // 300 misrouted flits: drop_count saturates, nothing stored
        drive(1'b1, 4'd1, 8'h99, 4'd5, 1'b0);
        for (int i = 0; i < 300; i++) tick();
        drive(1'b0, 4'd0, 8'h00, 4'd0, 1'b0);
        chk("sat_drop", {24'd0, drop_count}, 32'hFF);
        chk("sat_mis", {31'd0, misroute}, 32'd1);
        chk("sat_rx", {16'd0, rx_count}, 32'd7);
        chk("sat_valid", {31'd0, pl_valid}, 32'd0);

        // Concurrent push/pop at occupancy 2 across pointer wrap
        drive(1'b1, 4'd0, 8'h10, 4'd3, 1'b0);
        tick();
        drive(1'b1, 4'd1, 8'h11, 4'd3, 1'b0);
        tick();
        pop_idx = 0;
        for (int k = 2; k < 14; k++) begin
            drive(1'b1, k[3:0], 8'h10 + k[7:0], 4'd3, 1'b1);
            chk($sformatf("cc%0d_pl", k), {24'd0, pl_out}, {24'd0, 8'h10 + pop_idx[7:0]});
            chk($sformatf("cc%0d_src", k), {28'd0, src_out}, {28'd0, pop_idx[3:0]});
            tick();
            pop_idx++;
            chk($sformatf("cc%0d_valid", k), {31'd0, pl_valid}, 32'd1);
            chk($sformatf("cc%0d_busy", k), {31'd0, busy}, 32'd0);
        end
        drive(1'b0, 4'd0, 8'h00, 4'd0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("drain%0d_pl", k), {24'd0, pl_out}, {24'd0, 8'h10 + pop_idx[7:0]});
            tick();
            pop_idx++;
        end
        chk("drain_empty", {31'd0, pl_valid}, 32'd0);
        chk("cc_rx", {16'd0, rx_count}, 32'd21);
        chk("any_rx", {16'd0, rx_count2}, {16'd0, req_cycles});
        chk("any_mis", {31'd0, misroute2}, 32'd0);

        // Reset mid-stream while full
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'd8, 8'h20 + k[7:0], 4'd3, 1'b0);
            tick();
        end
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_valid", {31'd0, pl_valid}, 32'd0);
        chk("arst_rx", {16'd0, rx_count}, 32'd0);
        chk("arst_drop", {24'd0, drop_count}, 32'd0);
        chk("arst_any_rx", {16'd0, rx_count2}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 4'd9, 8'h66, 4'd3, 1'b0);
        tick();
        drive(1'b0, 4'd0, 8'h00, 4'd0, 1'b1);
        chk("post_valid", {31'd0, pl_valid}, 32'd1);
        chk("post_pl", {24'd0, pl_out}, 32'h66);
        chk("post_src", {28'd0, src_out}, 32'd9);
        chk("post_rx", {16'd0, rx_count}, 32'd1);
        tick();
        chk("post_alone", {31'd0, pl_valid}, 32'd0);
        chk("post_any_rx", {16'd0, rx_count2}, {16'd0, req_cycles});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
